mem_arbiter: RTL and testbench

Two-requester controller for the shared single-port RAM (combinational read, synchronous write on clk with wr_en). It arbitrates between port A (CPU MAR/MDR datapath) and port B (loader/DMA), and latches the winner's address, data and direction. It sequences exactly one RAM access per grant and returns read data with a one-cycle done pulse. It sits between the requesters and the RAM instance and is the only driver of the RAM ports.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester sequencer for a shared single-port RAM.
// One RAM access per grant, IDLE -> ACCESS -> DONE -> IDLE; done pulses in DONE.
// Optional macro RR_ARB_EN: round-robin tie-break between A and B.
// Without it, port A wins every tie (fixed priority).
module mem_arbiter #(
  parameter int depth = 9,
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [depth-1:0] a_addr,
  input  logic [width-1:0] a_wdata,
  output logic [width-1:0] a_rdata,
  output logic             a_done,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [depth-1:0] b_addr,
  input  logic [width-1:0] b_wdata,
  output logic [width-1:0] b_rdata,
  output logic             b_done,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [depth-1:0] ram_r_addr,
  output logic [depth-1:0] ram_w_addr,
  output logic [width-1:0] ram_w_data,
  output logic             ram_wr_en,
  input  logic [width-1:0] ram_r_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [depth-1:0] addr_q, addr_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [width-1:0] a_rdata_q, a_rdata_d;
  logic [width-1:0] b_rdata_q, b_rdata_d;
  logic             pick_b;

`ifdef RR_ARB_EN
  // pref_b_q names the port that wins the next tie; it flips away from each winner.
  logic pref_b_q, pref_b_d;
  assign pick_b = b_req && (!a_req || pref_b_q);
`else
  assign pick_b = b_req && !a_req;
`endif

  // Next-state logic: arbitration and latching in IDLE, read capture in ACCESS.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifdef RR_ARB_EN
    pref_b_d  = pref_b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          state_d = S_ACCESS;
          grant_d = pick_b ? 2'b10 : 2'b01;
          addr_d  = pick_b ? b_addr : a_addr;
          wdata_d = pick_b ? b_wdata : a_wdata;
          we_d    = pick_b ? b_we : a_we;
`ifdef RR_ARB_EN
          pref_b_d = !pick_b;
`endif
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (!we_q && grant_q[0]) a_rdata_d = ram_r_data;
        if (!we_q && grant_q[1]) b_rdata_d = ram_r_data;
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State registers with synchronous active-low clear taking priority.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef RR_ARB_EN
      pref_b_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef RR_ARB_EN
      pref_b_q  <= pref_b_d;
`endif
    end
  end

  // Address/data always reflect the latched request, so they never glitch.
  // Write enable is gated by clr_n so a clear landing on ACCESS cancels the write.
  assign ram_r_addr = addr_q;
  assign ram_w_addr = addr_q;
  assign ram_w_data = wdata_q;
  assign ram_wr_en  = clr_n && we_q && (state_q == S_ACCESS);

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign a_done  = (state_q == S_DONE) && grant_q[0];
  assign b_done  = (state_q == S_DONE) && grant_q[1];
  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model (memory array, expected rdata, tie rule).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [8:0]  a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic [31:0] a_rdata;
  logic        a_done;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [8:0]  b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [31:0] b_rdata;
  logic        b_done;
  logic [1:0]  grant;
  logic        busy;
  logic [8:0]  ram_r_addr, ram_w_addr;
  logic [31:0] ram_w_data, ram_r_data;
  logic        ram_wr_en;

  mem_arbiter #(.depth(9), .width(32)) dut (
    .clk(clk), .clr_n(clr_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_done(b_done),
    .grant(grant), .busy(busy),
    .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_wr_en(ram_wr_en), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // RAM: combinational read, synchronous write.
  logic [31:0] ram [512];
  assign ram_r_data = ram[ram_r_addr];
  always @(posedge clk) if (ram_wr_en) ram[ram_w_addr] <= ram_w_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [31:0] m_mem [512];
  logic [31:0] m_a_rd, m_b_rd;
  bit          m_pref_b;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_a_rd   = '0;
    m_b_rd   = '0;
    m_pref_b = 1'b0;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_a_done", a_done, 1'b0);
    check("rst_b_done", b_done, 1'b0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    check("rst_wr_en", ram_wr_en, 1'b0);
    clr_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Waits (bounded) for a done pulse; optionally disturbs the granted port's inputs.
  task automatic wait_done(output int port, output int lat, output int wr_pulses,
                           input int start, input bit perturb);
    port = -1;
    lat = -1;
    wr_pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ram_wr_en) wr_pulses++;
      if (a_done || b_done) begin
        port = a_done ? 0 : 1;
        lat  = cyc - start;
        return;
      end
      if (perturb && busy) begin
        if (grant[0]) begin
          a_addr = a_addr + 9'd1; a_wdata = ~a_wdata; a_we = ~a_we;
        end else if (grant[1]) begin
          b_addr = b_addr + 9'd1; b_wdata = ~b_wdata; b_we = ~b_we;
        end
      end
    end
  endtask

  task automatic model_apply(input int p, input bit we, input logic [8:0] addr,
                             input logic [31:0] wd);
    if (we) m_mem[addr] = wd;
    else if (p == 1) m_b_rd = m_mem[addr];
    else m_a_rd = m_mem[addr];
    m_pref_b = (p == 0);
  endtask

  task automatic serve(input bit a_on, input bit aw, input logic [8:0] aa, input logic [31:0] ad,
                       input bit b_on, input bit bw, input logic [8:0] ba, input logic [31:0] bd,
                       input bit perturb);
    int order[2];
    int n, start, first, p, gp, lat, wrp;
    bit we;
    logic [8:0] addr;
    logic [31:0] wd;
    a_req = a_on; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = b_on; b_we = bw; b_addr = ba; b_wdata = bd;
    start = cyc;
    if (a_on && b_on) begin
`ifdef RR_ARB_EN
      first = m_pref_b ? 1 : 0;
`else
      first = 0;
`endif
      order[0] = first; order[1] = 1 - first; n = 2;
    end else begin
      order[0] = a_on ? 0 : 1; order[1] = 0; n = 1;
    end
    for (int i = 0; i < n; i++) begin
      p    = order[i];
      we   = (p == 1) ? bw : aw;
      addr = (p == 1) ? ba : aa;
      wd   = (p == 1) ? bd : ad;
      wait_done(gp, lat, wrp, start, perturb);
      check("done_port", gp, p);
      check("done_exclusive", a_done & b_done, 1'b0);
      check("latency", lat, 2 + 3 * i);
      check("wr_pulses", wrp, we);
      check("grant_done", grant, (p == 1) ? 2'b10 : 2'b01);
      check("wr_en_done", ram_wr_en, 1'b0);
      model_apply(p, we, addr, wd);
      check("a_rdata", a_rdata, m_a_rd);
      check("b_rdata", b_rdata, m_b_rd);
      $display("txn port=%s we=%0d addr=0x%03h data=0x%08h lat=%0d",
               (p == 1) ? "B" : "A", we, addr, we ? wd : m_mem[addr], lat);
      if (p == 1) b_req = 1'b0; else a_req = 1'b0;
    end
    @(negedge clk);
    check("idle_grant", grant, 2'b00);
    check("idle_busy", busy, 1'b0);
    check("idle_done", a_done | b_done, 1'b0);
  endtask

  task automatic reset_mid_write();
    serve(1'b1, 1'b1, 9'h020, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 9'h020; a_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rmw_busy", busy, 1'b1);
    check("rmw_wr_en_access", ram_wr_en, 1'b1);
    clr_n = 1'b0;
    a_req = 1'b0;
    #1;
    check("rmw_wr_en_gated", ram_wr_en, 1'b0);
    @(negedge clk);
    check("rmw_grant", grant, 2'b00);
    check("rmw_busy_after", busy, 1'b0);
    check("rmw_done", a_done | b_done, 1'b0);
    check("rmw_a_rdata", a_rdata, 32'h0);
    check("rmw_b_rdata", b_rdata, 32'h0);
    clr_n = 1'b1;
    model_reset();
    $display("txn reset during write of 0x020");
    @(negedge clk);
    serve(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h020, 32'h0, 1'b0);
  endtask

  // Both ports hold requests for six grants; run right after a reset.
  task automatic fairness();
    int start, p, lat, wrp, exp_p;
    a_req = 1'b1; a_we = 1'b0; a_addr = 9'h005;
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'h1FF;
    start = cyc;
    for (int i = 0; i < 6; i++) begin
`ifdef RR_ARB_EN
      exp_p = i % 2;
`else
      exp_p = 0;
`endif
      wait_done(p, lat, wrp, start, 1'b0);
      check("fair_port", p, exp_p);
      check("fair_latency", lat, 2 + 3 * i);
      model_apply(exp_p, 1'b0, (exp_p == 1) ? 9'h1FF : 9'h005, 32'h0);
      check("fair_a_rdata", a_rdata, m_a_rd);
      check("fair_b_rdata", b_rdata, m_b_rd);
      $display("txn fairness grant %0d to %s", i, (p == 1) ? "B" : "A");
    end
    a_req = 1'b0;
`ifndef RR_ARB_EN
    wait_done(p, lat, wrp, start, 1'b0);
    check("fair_b_late", p, 1);
    check("fair_b_latency", lat, 20);
    model_apply(1, 1'b0, 9'h1FF, 32'h0);
    check("fair_b_rdata_late", b_rdata, m_b_rd);
    $display("txn fairness trailing grant to B");
`endif
    b_req = 1'b0;
    @(negedge clk);
    check("fair_idle", grant, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) m_mem[i] = '0;
    model_reset();
    do_reset();

    // Port A write then read.
    serve(1'b1, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
    serve(1'b1, 1'b0, 9'h005, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
    check("dir_a_read", a_rdata, 32'hDEADBEEF);

    // Port B read of a preloaded word.
    serve(1'b1, 1'b1, 9'h1FF, 32'h12345678, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
    serve(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h1FF, 32'h0, 1'b0);
    check("dir_b_read", b_rdata, 32'h12345678);
    check("dir_a_kept", a_rdata, 32'hDEADBEEF);

    // Simultaneous writes to the same address, then read back.
    serve(1'b1, 1'b1, 9'h010, 32'h11111111, 1'b1, 1'b1, 9'h010, 32'h22222222, 1'b0);
    serve(1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0);

    // Address change after grant must not affect the access.
    serve(1'b1, 1'b1, 9'h030, 32'hAAAA0030, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
    serve(1'b1, 1'b1, 9'h031, 32'hBBBB0031, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
    serve(1'b1, 1'b0, 9'h030, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1);
    check("dir_no_resample", a_rdata, 32'hAAAA0030);

    reset_mid_write();
    check("dir_rmw_ram", b_rdata, 32'h0);

    do_reset();
    fairness();

    // Randomized traffic over a small preloaded address window.
    for (int i = 0; i < 8; i++)
      serve(1'b1, 1'b1, 9'h040 + 9'(i), $urandom, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      int mode;
      bit pert;
      mode = $urandom_range(0, 2);
      pert = 1'($urandom_range(0, 1));
      serve(mode != 1, 1'($urandom_range(0, 1)), 9'h040 + 9'($urandom_range(0, 7)), $urandom,
            mode != 0, 1'($urandom_range(0, 1)), 9'h040 + 9'($urandom_range(0, 7)), $urandom,
            pert);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
